// File: rtl/bcd_counter_pkg.sv
// Shared types, active-low 7-segment codes and BCD helpers for the N-digit counter.
package bcd_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic bcd_t bcd_sat(input bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to active-low 7-segment pattern (bit0=a .. bit6=g); non-decimal codes blank.
module seg7_decoder
    import bcd_counter_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit BCD up/down counter with prescaler, clear/load, wrap pulse and 7-segment drive.
// Optional leading-zero blanking: define BCD_COUNTER_LEADING_ZERO_BLANK_EN.
module bcd_counter_ndigit
    import bcd_counter_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              up_down,
    input  logic              clear,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_value,
    output logic [4*NDIG-1:0] digits,
    output logic [7*NDIG-1:0] segments,
    output logic              tick,
    output logic              wrap
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    generate
        if (DIV < 1 || NDIG < 1 || NDIG > 8) begin : g_bad_cfg
            $error("bcd_counter_ndigit: need CLK_FREQ_HZ/TICK_HZ >= 1 and NDIG in 1..8");
        end
    endgenerate

    logic [PW-1:0]   pre_q, pre_d;
    bcd_t [NDIG-1:0] dig_q, dig_d;
    bcd_t [NDIG-1:0] inc, dec, ldv;
    logic            tick_q, tick_d, wrap_q, wrap_d;
    logic            step, cy, bw;

    assign step = enable && (pre_q == PRE_LAST);

    // Ripple carry/borrow across digits; carry out of the top digit is the wrap.
    always_comb begin
        cy = 1'b1;
        bw = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            inc[i] = dig_q[i];
            dec[i] = dig_q[i];
            ldv[i] = bcd_sat(load_value[4*i +: 4]);
            if (cy) begin
                if (dig_q[i] == 4'd9) inc[i] = 4'd0;
                else begin
                    inc[i] = dig_q[i] + 4'd1;
                    cy     = 1'b0;
                end
            end
            if (bw) begin
                if (dig_q[i] == 4'd0) dec[i] = 4'd9;
                else begin
                    dec[i] = dig_q[i] - 4'd1;
                    bw     = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pre_d  = pre_q;
        dig_d  = dig_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (enable) pre_d = step ? '0 : pre_q + PW'(1);
        if (clear) begin
            dig_d = '0;
            pre_d = '0;
        end else if (load) begin
            dig_d = ldv;
        end else if (step) begin
            dig_d  = up_down ? inc : dec;
            tick_d = 1'b1;
            wrap_d = up_down ? cy : bw;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            dig_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            dig_q  <= dig_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign digits = dig_q;
    assign tick   = tick_q;
    assign wrap   = wrap_q;

    logic [NDIG-1:0] lit;
`ifdef BCD_COUNTER_LEADING_ZERO_BLANK_EN
    logic seen;
    // Scan from the top: a digit is lit once any digit at or above it is non-zero; digit 0 always lit.
    always_comb begin
        seen = 1'b0;
        lit  = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            seen   = seen | (dig_q[i] != 4'd0);
            lit[i] = seen || (i == 0);
        end
    end
`else
    assign lit = '1;
`endif

    logic [NDIG-1:0][6:0] seg_raw;

    generate
        for (genvar g = 0; g < NDIG; g++) begin : g_dig
            seg7_decoder u_dec (
                .bcd_i (dig_q[g]),
                .seg_o (seg_raw[g])
            );
            assign segments[7*g +: 7] = lit[g] ? seg_raw[g] : SEG_BLANK;
        end
    endgenerate

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Scoreboard bench for bcd_counter_ndigit (NDIG=4, DIV=4) against a decimal-integer reference model.
module tb_bcd_counter_ndigit;

    localparam int NDIG = 4;
    localparam int DIV  = 4;
    localparam int MOD  = 10000;
    localparam logic [6:0] SEGT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0, up_down = 1'b1, clear = 1'b0, load = 1'b0;
    logic [4*NDIG-1:0] load_value = '0;
    logic [4*NDIG-1:0] digits;
    logic [7*NDIG-1:0] segments;
    logic              tick, wrap;

    bcd_counter_ndigit #(.NDIG(NDIG), .CLK_FREQ_HZ(4), .TICK_HZ(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .digits(digits), .segments(segments), .tick(tick), .wrap(wrap)
    );

    always #5 clock = ~clock;

    typedef struct { int val; bit tk; bit wr; } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_fail = 0;
    int m_val = 0, m_pre = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) begin
            int d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] exp_seg(input int v);
        logic [27:0] r = '0;
        int p = 1;
        for (int i = 0; i < 4; i++) begin
            r[7*i +: 7] = SEGT[(v / p) % 10];
`ifdef BCD_COUNTER_LEADING_ZERO_BLANK_EN
            if (i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    // Advance the model with the inputs currently driven, then compare after the edge.
    task automatic cycle();
        exp_t e, got;
        bit st;
        e.tk = 0;
        e.wr = 0;
        st = enable && (m_pre == DIV - 1);
        if (clear) begin
            m_val = 0;
            m_pre = 0;
        end else begin
            if (enable) m_pre = st ? 0 : m_pre + 1;
            if (load) m_val = bcd2int(load_value);
            else if (st) begin
                e.tk = 1;
                if (up_down) begin
                    if (m_val == MOD - 1) begin m_val = 0; e.wr = 1; end
                    else m_val++;
                end else begin
                    if (m_val == 0) begin m_val = MOD - 1; e.wr = 1; end
                    else m_val--;
                end
            end
        end
        e.val = m_val;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            chk("digits", digits, int2bcd(got.val));
            chk("tick", tick, got.tk);
            chk("wrap", wrap, got.wr);
            chk("segments", segments, exp_seg(got.val));
        end
    endtask

    task automatic run(input int n, input logic en, input logic ud);
        enable  = en;
        up_down = ud;
        clear   = 0;
        load    = 0;
        repeat (n) cycle();
    endtask

    task automatic do_load(input logic [15:0] v);
        load       = 1;
        load_value = v;
        cycle();
        load = 0;
    endtask

    initial begin
        #22;
        chk("rst_digits", digits, 16'h0000);
        chk("rst_tick", tick, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_seg", segments, {4{7'b1000000}});
        reset = 1;
        m_val = 0;
        m_pre = 0;

        // basic up count
        run(12, 1, 1);
        chk("t1_digits", digits, 16'h0003);
        chk("t1_seg0", segments[6:0], 7'b0110000);

        // up wrap 9999 -> 0000
        do_load(16'h9998);
        run(8, 1, 1);
        chk("t2_digits", digits, 16'h0000);

        // down wrap 0000 -> 9999 -> 9998
        do_load(16'h0000);
        run(8, 1, 0);
        chk("t3_digits", digits, 16'h9998);

        // saturation, clear priority, pause
        do_load(16'h0F19);
        chk("t4_sat", digits, 16'h0919);
        clear = 1;
        do_load(16'h5555);
        clear = 0;
        chk("t4_clr", digits, 16'h0000);
        run(20, 0, 1);
        chk("t4_frozen", digits, 16'h0000);

        // async reset mid-prescale
        enable = 1;
        do_load(16'h0123);
        run(2, 1, 1);
        chk("t5_pre", digits, 16'h0123);
        #2 reset = 0;
        #1;
        chk("t5_rst_digits", digits, 16'h0000);
        chk("t5_rst_tick", tick, 1'b0);
        chk("t5_rst_seg", segments, {4{7'b1000000}});
        m_val = 0;
        m_pre = 0;
        #2 reset = 1;
        run(3, 1, 1);
        chk("t5_no_tick", tick, 1'b0);
        run(1, 1, 1);
        chk("t5_first_tick", tick, 1'b1);
        chk("t5_digits", digits, 16'h0001);

`ifdef BCD_COUNTER_LEADING_ZERO_BLANK_EN
        enable = 0;
        do_load(16'h0042);
        chk("t6_blank42", segments, {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100});
        do_load(16'h0000);
        chk("t6_blank0", segments, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
`endif

        // randomized traffic, biased toward boundary loads
        for (int k = 0; k < 400; k++) begin
            int r;
            enable  = ($urandom % 8) != 0;
            if ($urandom % 20 == 0) up_down = ~up_down;
            clear   = ($urandom % 50) == 0;
            load    = ($urandom % 15) == 0;
            r = $urandom % 4;
            load_value = (r == 0) ? 16'h9999 : (r == 1) ? 16'h0000 :
                         (r == 2) ? 16'h0998 : 16'($urandom);
            cycle();
        end
        clear = 0;
        load  = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
